fifo_unpack: RTL

// - Width-splitting FIFO: accepts 16-bit words, emits them as 8-bit bytes, low byte first.
// - Inverse of the 8->16 packing FIFO; sits on the transmit side and feeds a byte-wide sink.
// - Storage holds DEPTH words; a byte-select flag tracks which half of the head word goes next.

---
 rtl/fifo_unpack_if.sv | 35 +++
 rtl/fifo_unpack.sv | 70 +++++++
 2 files changed

// File: rtl/fifo_unpack_if.sv
// Handshake bundle for fifo_unpack: 16-bit word ingress, 8-bit byte egress.
// Optional feature macro: FIFO_LEVEL_EN adds the 'level' occupancy signal.
interface fifo_unpack_if
`ifdef FIFO_LEVEL_EN
    #(parameter int ADDR_W = 5)
`endif
    ;
    logic [15:0]     data_in;
    logic            input_valid;
    logic            input_enable;
    logic            output_enable;
    logic            output_valid;
    logic [7:0]      data_out;
`ifdef FIFO_LEVEL_EN
    logic [ADDR_W:0] level;

    modport master (
        output data_in, input_valid, output_enable,
        input  input_enable, output_valid, data_out, level
    );
    modport slave (
        input  data_in, input_valid, output_enable,
        output input_enable, output_valid, data_out, level
    );
`else
    modport master (
        output data_in, input_valid, output_enable,
        input  input_enable, output_valid, data_out
    );
    modport slave (
        input  data_in, input_valid, output_enable,
        output input_enable, output_valid, data_out
    );
`endif
endinterface

// File: rtl/fifo_unpack.sv
// Width-splitting FIFO: stores 16-bit words, emits 8-bit bytes low byte first.
// Show-ahead output; a byte-select flag picks which half of the head word is
// presented. A word is retired only after its high byte is taken.
// Optional feature macro: FIFO_LEVEL_EN exposes the word count on bus.level.
module fifo_unpack #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input logic          clk,
    input logic          rst,
    fifo_unpack_if.slave bus
);
    localparam logic [ADDR_W-1:0] PTR_ONE  = 1;
    localparam logic [ADDR_W:0]   CNT_ONE  = 1;
    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);

    logic [15:0]       r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_byte_sel;

    logic              w_in_en;
    logic              w_out_vld;
    logic              w_push;
    logic              w_pop;
    logic              w_retire;
    logic [15:0]       w_head;

    // Flow control depends on registered count only, so a retire while full
    // does not open the input until the following cycle.
    assign w_in_en   = !rst && (r_count != CNT_FULL);
    assign w_out_vld = !rst && (r_count != '0);
    assign w_push    = bus.input_valid && w_in_en;
    assign w_pop     = w_out_vld && bus.output_enable;
    assign w_retire  = w_pop && r_byte_sel;
    assign w_head    = r_mem[r_rd_ptr];

    assign bus.input_enable = w_in_en;
    assign bus.output_valid = w_out_vld;
    assign bus.data_out     = !w_out_vld ? 8'h00 :
                              (r_byte_sel ? w_head[15:8] : w_head[7:0]);
`ifdef FIFO_LEVEL_EN
    assign bus.level        = r_count;
`endif

    // Word storage; contents survive reset, only pointers are cleared.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= bus.data_in;
    end

    // Pointers, occupancy and half-word select.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_byte_sel <= 1'b0;
        end else begin
            if (w_push)   r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_retire) r_rd_ptr <= r_rd_ptr + PTR_ONE;
            if (w_pop)    r_byte_sel <= !r_byte_sel;
            case ({w_push, w_retire})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
